// File: rtl/sobel_edge_stage.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a 3x3 window, and a
// two-stage pipeline turns |Gx|+|Gy| into a 0/255 edge map tagged with centre coordinates.
module sobel_edge_stage #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int BITS_FOR_INDEX = 10,
    parameter int THRESHOLD      = 100
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_pixel,
    output logic                      out_valid,
    output logic [7:0]                out_pixel,
    output logic [BITS_FOR_INDEX-1:0] out_row,
    output logic [BITS_FOR_INDEX-1:0] out_col,
    output logic                      frame_done
);
    localparam int                        STAGES   = 2;
    localparam int                        AW       = $clog2(WIDTH);
    localparam logic [7:0]                THR      = 8'(THRESHOLD);
    localparam logic [BITS_FOR_INDEX-1:0] LAST_COL = BITS_FOR_INDEX'(WIDTH - 1);
    localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW = BITS_FOR_INDEX'(HEIGHT - 1);
    localparam logic [BITS_FOR_INDEX-1:0] IDX2     = BITS_FOR_INDEX'(2);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      r_state;
    logic                        r_in_ready;
    logic                        r_frame_done;
    logic [BITS_FOR_INDEX-1:0]   r_row;
    logic [BITS_FOR_INDEX-1:0]   r_col;
    logic [STAGES:0]             r_vld_pipe;

    logic [7:0]                  r_lb0 [WIDTH];
    logic [7:0]                  r_lb1 [WIDTH];
    logic [2:0][2:0][7:0]        r_win;
    logic [BITS_FOR_INDEX-1:0]   r_win_row, r_win_col;

    logic signed [10:0]          r_gx, r_gy;
    logic [BITS_FOR_INDEX-1:0]   r_s1_row, r_s1_col;

    logic [7:0]                  r_out_pixel;
    logic [BITS_FOR_INDEX-1:0]   r_out_row, r_out_col;

    logic                        w_accept, w_launch, w_last_col, w_last_row;
    logic [AW-1:0]               w_addr;
    logic [9:0]                  w_col_l, w_col_r, w_row_t, w_row_b;
    logic signed [10:0]          w_gx, w_gy;
    logic [10:0]                 w_ax, w_ay;
    logic [11:0]                 w_mag;
    logic [7:0]                  w_sat;

    assign w_accept   = in_valid & r_in_ready;
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    assign w_addr     = r_col[AW-1:0];
    // Only RUN (row >= 2) with col >= 2 completes a full 3x3 window of the current line.
    assign w_launch   = w_accept && (r_state == S_RUN) && (r_col >= IDX2);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (w_accept && r_row == IDX2 && r_col == '0) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept && w_last_row && w_last_col) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                // Leave once nothing upstream of the output register is still in flight,
                // so frame_done lands the cycle after the last out_valid.
                S_DRAIN: begin
                    if (!r_vld_pipe[0] && !r_vld_pipe[1]) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_row      <= '0;
                    r_col      <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_lb1[w_addr] <= r_lb0[w_addr];
            r_lb0[w_addr] <= in_pixel;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_win     <= '0;
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= r_lb1[w_addr];
            r_win[1][2] <= r_lb0[w_addr];
            r_win[2][2] <= in_pixel;
            if (w_launch) begin
                r_win_row <= r_row - 1'b1;
                r_win_col <= r_col - 1'b1;
            end
        end
    end

    assign w_col_l = 10'(r_win[0][0]) + {1'b0, r_win[1][0], 1'b0} + 10'(r_win[2][0]);
    assign w_col_r = 10'(r_win[0][2]) + {1'b0, r_win[1][2], 1'b0} + 10'(r_win[2][2]);
    assign w_row_t = 10'(r_win[0][0]) + {1'b0, r_win[0][1], 1'b0} + 10'(r_win[0][2]);
    assign w_row_b = 10'(r_win[2][0]) + {1'b0, r_win[2][1], 1'b0} + 10'(r_win[2][2]);
    assign w_gx    = $signed({1'b0, w_col_r}) - $signed({1'b0, w_col_l});
    assign w_gy    = $signed({1'b0, w_row_b}) - $signed({1'b0, w_row_t});

    assign w_ax  = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    assign w_ay  = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_sat = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_vld_pipe  <= '0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_s1_row    <= '0;
            r_s1_col    <= '0;
            r_out_pixel <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_launch};
            if (r_vld_pipe[0]) begin
                r_gx     <= w_gx;
                r_gy     <= w_gy;
                r_s1_row <= r_win_row;
                r_s1_col <= r_win_col;
            end
            if (r_vld_pipe[1]) begin
                r_out_pixel <= (w_sat >= THR) ? 8'd255 : 8'd0;
                r_out_row   <= r_s1_row;
                r_out_col   <= r_s1_col;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_vld_pipe[STAGES];
    assign out_pixel  = r_out_pixel;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Bench for sobel_edge_stage: three instances (thresholds 100/200/201) share one
// input stream; a frame-level Sobel model built from the whole image scores every output.
module tb_sobel_edge_stage;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (H - 2) * (W - 2);

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       ov [3];
    logic [7:0] op [3];
    logic [9:0] orow [3];
    logic [9:0] ocol [3];
    logic       fd [3];
    logic       ir [3];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sobel_edge_stage #(
            .WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(10),
            .THRESHOLD((g == 0) ? 100 : (g == 1) ? 200 : 201)
        ) u_dut (
            .HCLK(HCLK), .HRESETn(HRESETn),
            .in_valid(in_valid), .in_ready(ir[g]), .in_pixel(in_pixel),
            .out_valid(ov[g]), .out_pixel(op[g]), .out_row(orow[g]), .out_col(ocol[g]),
            .frame_done(fd[g])
        );
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int img      [H][W];
    int acc_edge [H][W];
    int exp_row  [NOUT];
    int exp_col  [NOUT];
    int exp_mag  [NOUT];
    int out_cnt  [3];
    int done_cnt;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int thr_of(input int k);
        return (k == 0) ? 100 : (k == 1) ? 200 : 201;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int edge_of(input int mag, input int thr);
        int sat;
        sat = (mag > 255) ? 255 : mag;
        return (sat >= thr) ? 255 : 0;
    endfunction

    // 0 uniform, 1 vertical step, 2 ramp, 3 gentle noise, 4 full-range noise
    task automatic set_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = 50;
                    1:       img[r][c] = (c >= 4) ? 200 : 0;
                    2:       img[r][c] = 25 * c;
                    3:       img[r][c] = 80 + int'($urandom_range(40));
                    default: img[r][c] = int'($urandom_range(255));
                endcase
    endtask

    task automatic build_expected();
        int n, gx, gy;
        n = 0;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
                   - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
                gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
                   - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
                exp_row[n] = r;
                exp_col[n] = c;
                exp_mag[n] = iabs(gx) + iabs(gy);
                n++;
            end
        for (int k = 0; k < 3; k++) out_cnt[k] = 0;
        done_cnt = 0;
    endtask

    always @(negedge HCLK) begin
        if (fd[0]) begin
            done_cnt++;
            chk("done_with_valid", 32'(ov[0]), 0);
        end
        for (int k = 0; k < 3; k++) begin
            if (ov[k]) begin
                if (out_cnt[k] < NOUT) begin
                    chk($sformatf("row%0d", k), 32'(orow[k]), exp_row[out_cnt[k]]);
                    chk($sformatf("col%0d", k), 32'(ocol[k]), exp_col[out_cnt[k]]);
                    chk($sformatf("pix%0d", k), 32'(op[k]),
                        edge_of(exp_mag[out_cnt[k]], thr_of(k)));
                    if (k == 0)
                        chk("latency", cyc - acc_edge[exp_row[0 + out_cnt[0]] + 1][exp_col[out_cnt[0]] + 1], 2);
                end else begin
                    chk($sformatf("out_overflow%0d", k), out_cnt[k], NOUT - 1);
                end
                out_cnt[k]++;
            end
        end
    end

    // Called at posedge+1; leaves at posedge+1 after the accepting edge.
    task automatic send_pixel(input int r, input int c, input int duty);
        int guard;
        while (int'($urandom_range(99)) >= duty) begin
            in_valid = 1'b0;
            @(posedge HCLK); #1;
        end
        in_valid = 1'b1;
        in_pixel = 8'(img[r][c]);
        guard = 0;
        @(negedge HCLK);
        while (!ir[0] && guard < 50) begin
            @(negedge HCLK);
            guard++;
        end
        if (!ir[0]) chk("ready_timeout", 32'(ir[0]), 1);
        acc_edge[r][c] = cyc + 1;
        @(posedge HCLK); #1;
    endtask

    task automatic end_checks(input string name);
        chk({name, "_done_cnt"}, done_cnt, 1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_outs%0d", name, k), out_cnt[k], NOUT);
    endtask

    task automatic run_frame(input string name, input int mode, input int duty);
        set_img(mode);
        build_expected();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(r, c, duty);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge HCLK);
        repeat (3) @(negedge HCLK);
        end_checks(name);
        @(posedge HCLK); #1;
    endtask

    initial begin
        HRESETn  = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) out_cnt[k] = 0;
        #2;
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_out_pixel", 32'(op[0]), 0);
        chk("rst_out_row", 32'(orow[0]), 0);
        chk("rst_out_col", 32'(ocol[0]), 0);
        chk("rst_frame_done", 32'(fd[0]), 0);
        chk("rst_in_ready", 32'(ir[0]), 0);
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        chk("idle_ready", 32'(ir[0]), 1);

        run_frame("uniform", 0, 100);
        run_frame("step", 1, 100);
        run_frame("ramp", 2, 100);
        run_frame("step_gaps", 1, 50);

        // Mid-frame asynchronous reset while outputs of the partial frame are live
        set_img(1);
        build_expected();
        for (int i = 0; i < 20; i++) send_pixel(i / W, i % W, 100);
        in_valid = 1'b0;
        @(posedge HCLK); #3;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(ov[0]), 0);
        chk("mid_rst_out_pixel", 32'(op[0]), 0);
        chk("mid_rst_out_row", 32'(orow[0]), 0);
        chk("mid_rst_out_col", 32'(ocol[0]), 0);
        chk("mid_rst_frame_done", 32'(fd[0]), 0);
        chk("mid_rst_in_ready", 32'(ir[0]), 0);
        @(negedge HCLK);
        chk("mid_rst_ready_low", 32'(ir[0]), 0);
        @(posedge HCLK); #3;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        run_frame("after_rst", 0, 100);

        // in_valid held high across DRAIN/DONE: nothing further may be accepted
        set_img(4);
        build_expected();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(r, c, 100);
        in_pixel = 8'd77;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge HCLK);
                chk("drain_ready_low", 32'(ir[0]), 0);
                seen = fd[0];
            end
            if (!seen) chk("hold_done_timeout", 32'(fd[0]), 1);
        end
        in_valid = 1'b0;
        @(negedge HCLK);
        chk("idle_ready_back", 32'(ir[0]), 1);
        repeat (3) @(negedge HCLK);
        end_checks("hold");
        @(posedge HCLK); #1;

        run_frame("noise_gaps", 3, 70);
        run_frame("noise_full", 4, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
